// File: rtl/i2c_target_rx_if.sv
// Host-side read port of the I2C target receive FIFO.
// The host holds the master modport and the receiver holds the slave modport.
interface i2c_target_rx_if #(
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [LW-1:0] level;

    modport master (output rd_en, input rd_data, input rd_valid, input level);
    modport slave  (input rd_en, output rd_data, output rd_valid, output level);
endinterface

// File: rtl/i2c_target_rx.sv
// I2C target-write receiver: SCL/SDA sync, START/STOP detect, address match, open-drain ACK, FWFT byte FIFO.
// Define I2C_RX_GENERAL_CALL_EN to also accept the general-call address byte 8'h00.
module i2c_target_rx #(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         DEPTH       = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    inout  wire              i2c_scl,
    inout  wire              i2c_sda,
    input  logic             en,
    i2c_target_rx_if.slave   rd_if,
    output logic             overflow,
    input  logic             ovf_clr,
    output logic             busy,
    output logic             stop_pulse
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } state_t;

    // Stage p0: pin synchronisers (idle bus reads high)
    logic [SYNC_STAGES-1:0] scl_meta;
    logic [SYNC_STAGES-1:0] sda_meta;
    logic                   scl_p0;
    logic                   sda_p0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            scl_meta <= '1;
            sda_meta <= '1;
        end else begin
            scl_meta <= {scl_meta[SYNC_STAGES-2:0], i2c_scl};
            sda_meta <= {sda_meta[SYNC_STAGES-2:0], i2c_sda};
        end
    end

    assign scl_p0 = scl_meta[SYNC_STAGES-1];
    assign sda_p0 = sda_meta[SYNC_STAGES-1];

    // Stage p1: one extra delay flop for edge detection
    logic scl_p1;
    logic sda_p1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            scl_p1 <= 1'b1;
            sda_p1 <= 1'b1;
        end else begin
            scl_p1 <= scl_p0;
            sda_p1 <= sda_p0;
        end
    end

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_rise  =  scl_p0 && !scl_p1;
    assign scl_fall  = !scl_p0 &&  scl_p1;
    assign start_det =  scl_p0 && !sda_p0 &&  sda_p1;
    assign stop_det  =  scl_p0 &&  sda_p0 && !sda_p1;

    // Shift register holds the first seven bits; the eighth is taken live so the
    // byte can be judged on the very edge it completes.
    logic [6:0] shift_q;
    logic [7:0] rx_byte;

    always_ff @(posedge clk) begin
        if (scl_rise) begin
            shift_q <= {shift_q[5:0], sda_p0};
        end
    end

    assign rx_byte = {shift_q, sda_p0};

    logic gc_hit;
`ifdef I2C_RX_GENERAL_CALL_EN
    assign gc_hit = (rx_byte == 8'h00);
`else
    assign gc_hit = 1'b0;
`endif

    logic addr_hit;
    assign addr_hit = ((rx_byte[7:1] == ADDR) && !rx_byte[0]) || gc_hit;

    // FIFO storage and pointers
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          fifo_full;
    logic          push;
    logic          pop;

    assign fifo_full = (level == FULL_LVL);
    assign pop       = rd_if.rd_en && (level != '0);

    state_t     state;
    logic [2:0] bit_cnt;
    logic       sda_oe;
    logic       bit8;
    logic       ctl_ok;

    assign bit8   = scl_rise && (bit_cnt == 3'd7);
    assign ctl_ok = en && !stop_det && !start_det;
    assign push   = ctl_ok && (state == S_DATA) && bit8 && !fifo_full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: ;
            endcase
        end
    end

    assign rd_if.rd_valid = (level != '0);
    assign rd_if.rd_data  = (level != '0) ? mem[rd_ptr] : 8'h00;
    assign rd_if.level    = level;

    // Stage p2: protocol FSM; bus conditions override bit sampling
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            bit_cnt    <= 3'd0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            stop_pulse <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            stop_pulse <= 1'b0;
            if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (!en) begin
                state   <= S_IDLE;
                bit_cnt <= 3'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (stop_det) begin
                state      <= S_IDLE;
                bit_cnt    <= 3'd0;
                sda_oe     <= 1'b0;
                busy       <= 1'b0;
                stop_pulse <= 1'b1;
            end else if (start_det) begin
                state   <= S_ADDR;
                bit_cnt <= 3'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b1;
            end else begin
                case (state)
                    S_ADDR: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        if (bit8) begin
                            state <= addr_hit ? S_ADDR_ACK : S_IGNORE;
                        end
                    end
                    S_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        if (bit8) begin
                            if (fifo_full) begin
                                overflow <= 1'b1;
                                state    <= S_IGNORE;
                            end else begin
                                state <= S_DATA_ACK;
                            end
                        end
                    end
                    // First SCL fall after the byte starts the ACK, the next one ends it
                    S_ADDR_ACK, S_DATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 3'd0;
                                state   <= S_DATA;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: table of write transactions plus hand-written
// sequences for FIFO overflow, repeated START and reset during an ACK bit.
module tb_i2c_target_rx;
    localparam int Q  = 10;
    localparam int NV = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    logic en;
    logic ovf_clr;
    logic m_scl;
    logic m_sda;
    logic overflow;
    logic busy;
    logic stop_pulse;
    wire  i2c_scl;
    wire  i2c_sda;

    assign i2c_scl = m_scl ? 1'bz : 1'b0;
    assign i2c_sda = m_sda ? 1'bz : 1'b0;
    pullup (i2c_scl);
    pullup (i2c_sda);

    i2c_target_rx_if #(.DEPTH(8)) rd_if ();

    i2c_target_rx #(.ADDR(7'h42), .DEPTH(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i2c_scl    (i2c_scl),
        .i2c_sda    (i2c_sda),
        .en         (en),
        .rd_if      (rd_if),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .busy       (busy),
        .stop_pulse (stop_pulse)
    );

    typedef struct {
        logic [7:0]      addr;
        int              n;
        logic [1:0][7:0] d;
        logic            aack;
        int              lvl;
    } vec_t;

    vec_t vecs [NV];
    int   checks   = 0;
    int   failures = 0;
    int   sp_cnt   = 0;
    int   drv_cnt  = 0;

    // Counts stop pulses and cycles where the DUT pulls SDA low while the master releases it
    always @(negedge clk) begin
        #1;
        if (stop_pulse) sp_cnt++;
        if (m_sda && !i2c_sda) drv_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [7:0] a, input int n, input logic [7:0] d0,
                                input logic [7:0] d1, input logic aack, input int lvl);
        vec_t r;
        r.addr = a;
        r.n    = n;
        r.d[0] = d0;
        r.d[1] = d1;
        r.aack = aack;
        r.lvl  = lvl;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic waitq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; waitq();
        m_scl = 1'b1; waitq();
        m_sda = 1'b0; waitq();
        m_scl = 1'b0; waitq();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; waitq();
        m_scl = 1'b1; waitq();
        m_sda = 1'b1; waitq();
        waitq();
    endtask

    task automatic i2c_bit(input logic b);
        m_sda = b;    waitq();
        m_scl = 1'b1; waitq(); waitq();
        m_scl = 1'b0; waitq();
    endtask

    task automatic i2c_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
        m_sda = 1'b1; waitq();
        m_scl = 1'b1; waitq();
        @(negedge clk);
        acked = !i2c_sda;
        waitq();
        m_scl = 1'b0; waitq();
    endtask

    task automatic pop_chk(input string nm, input logic [7:0] exp);
        chk({nm, "_valid"}, 32'(rd_if.rd_valid), 32'd1);
        chk({nm, "_data"}, 32'(rd_if.rd_data), 32'(exp));
        rd_if.rd_en = 1'b1;
        @(negedge clk);
        rd_if.rd_en = 1'b0;
    endtask

    initial begin
        logic ack;
        logic seen;
        int   sp0;
        int   dv0;

        vecs[0] = mk(8'h84, 2, 8'hA5, 8'h3C, 1'b1, 2);
        vecs[1] = mk(8'h86, 1, 8'h55, 8'h00, 1'b0, 0);
        vecs[2] = mk(8'h85, 1, 8'h12, 8'h00, 1'b0, 0);
`ifdef I2C_RX_GENERAL_CALL_EN
        vecs[3] = mk(8'h00, 1, 8'h5A, 8'h00, 1'b1, 1);
`else
        vecs[3] = mk(8'h00, 1, 8'h5A, 8'h00, 1'b0, 0);
`endif
        vecs[4] = mk(8'h84, 2, 8'hFF, 8'h00, 1'b1, 2);

        m_scl       = 1'b1;
        m_sda       = 1'b1;
        en          = 1'b1;
        ovf_clr     = 1'b0;
        rd_if.rd_en = 1'b0;
        rstn        = 1'b0;
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        chk("rst_rd_data", 32'(rd_if.rd_data), 32'h0);
        chk("rst_rd_valid", 32'(rd_if.rd_valid), 32'h0);
        chk("rst_level", 32'(rd_if.level), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_stop_pulse", 32'(stop_pulse), 32'h0);
        chk("rst_sda", 32'(i2c_sda), 32'h1);

        for (int k = 0; k < NV; k++) begin
            sp0 = sp_cnt;
            dv0 = drv_cnt;
            i2c_start();
            i2c_byte(vecs[k].addr, ack);
            chk($sformatf("v%0d_addr_ack", k), 32'(ack), 32'(vecs[k].aack));
            for (int j = 0; j < vecs[k].n; j++) begin
                i2c_byte(vecs[k].d[j], ack);
                chk($sformatf("v%0d_data%0d_ack", k, j), 32'(ack), 32'(vecs[k].aack));
            end
            chk($sformatf("v%0d_busy", k), 32'(busy), 32'h1);
            i2c_stop();
            chk($sformatf("v%0d_stop_pulses", k), 32'(sp_cnt - sp0), 32'd1);
            chk($sformatf("v%0d_busy_after", k), 32'(busy), 32'h0);
            chk($sformatf("v%0d_sda_driven", k), 32'((drv_cnt - dv0) > 0), 32'(vecs[k].aack));
            chk($sformatf("v%0d_level", k), 32'(rd_if.level), 32'(vecs[k].lvl));
            for (int j = 0; j < vecs[k].lvl; j++) pop_chk($sformatf("v%0d_pop%0d", k, j), vecs[k].d[j]);
            chk($sformatf("v%0d_level_empty", k), 32'(rd_if.level), 32'h0);
        end

        // Nine bytes into an eight-deep FIFO with no pops
        i2c_start();
        i2c_byte(8'h84, ack);
        chk("ovf_addr_ack", 32'(ack), 32'h1);
        for (int j = 0; j < 9; j++) begin
            i2c_byte(8'(j), ack);
            chk($sformatf("ovf_data%0d_ack", j), 32'(ack), 32'(j < 8));
        end
        chk("ovf_flag", 32'(overflow), 32'h1);
        chk("ovf_level", 32'(rd_if.level), 32'd8);
        i2c_stop();
        chk("ovf_flag_after_stop", 32'(overflow), 32'h1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'h0);
        for (int j = 0; j < 8; j++) pop_chk($sformatf("ovf_pop%0d", j), 8'(j));
        chk("ovf_level_empty", 32'(rd_if.level), 32'h0);

        // Repeated START after four bits of a data byte
        i2c_start();
        i2c_byte(8'h84, ack);
        chk("rs_addr1_ack", 32'(ack), 32'h1);
        i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b1); i2c_bit(1'b1);
        i2c_start();
        chk("rs_level_partial", 32'(rd_if.level), 32'h0);
        i2c_byte(8'h84, ack);
        chk("rs_addr2_ack", 32'(ack), 32'h1);
        i2c_byte(8'h77, ack);
        chk("rs_data_ack", 32'(ack), 32'h1);
        i2c_stop();
        chk("rs_level", 32'(rd_if.level), 32'd1);
        pop_chk("rs_pop", 8'h77);
        chk("rs_level_empty", 32'(rd_if.level), 32'h0);

        // Reset asserted while the DUT is driving the data ACK
        i2c_start();
        i2c_byte(8'h84, ack);
        chk("ra_addr_ack", 32'(ack), 32'h1);
        for (int i = 7; i >= 0; i--) i2c_bit(1'(8'hC3 >> i));
        chk("ra_level_pushed", 32'(rd_if.level), 32'd1);
        m_sda = 1'b1;
        seen  = 1'b0;
        for (int t = 0; t < 4 * Q && !seen; t++) begin
            @(negedge clk);
            if (!i2c_sda) seen = 1'b1;
        end
        chk("ra_ack_drive_seen", 32'(seen), 32'h1);
        rstn = 1'b0;
        @(negedge clk);
        chk("ra_sda_released", 32'(i2c_sda), 32'h1);
        chk("ra_level_cleared", 32'(rd_if.level), 32'h0);
        chk("ra_rd_valid", 32'(rd_if.rd_valid), 32'h0);
        rstn = 1'b1;
        m_scl = 1'b1; waitq();
        m_scl = 1'b0; waitq();
        i2c_stop();
        i2c_start();
        i2c_byte(8'h84, ack);
        chk("ra2_addr_ack", 32'(ack), 32'h1);
        i2c_byte(8'h11, ack);
        chk("ra2_data_ack", 32'(ack), 32'h1);
        i2c_stop();
        chk("ra2_level", 32'(rd_if.level), 32'd1);
        pop_chk("ra2_pop", 8'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
